// File: rtl/dsp_loop_ctrl_pkg.sv
// Shared widths, defaults and stack-operation encoding for the zero-overhead loop controller.
package dsp_loop_ctrl_pkg;
  localparam int MEM_ADDR_LEN_DEF = 16;
  localparam int CNT_W_DEF        = 16;
  localparam int DEPTH_DEF        = 4;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_REPL = 2'd3
  } stk_op_e;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/dsp_loop_stack.sv
// LIFO of loop entries {start, end, remaining count} with push/pop/replace and top-count update.
module dsp_loop_stack
  import dsp_loop_ctrl_pkg::*;
#(
  parameter int AW    = MEM_ADDR_LEN_DEF,
  parameter int CW    = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  stk_op_e       op_i,
  input  logic [AW-1:0] push_start_i,
  input  logic [AW-1:0] push_end_i,
  input  logic [CW-1:0] push_cnt_i,
  input  logic          upd_i,
  input  logic [CW-1:0] upd_cnt_i,
  output logic [AW-1:0] top_start_o,
  output logic [AW-1:0] top_end_o,
  output logic [CW-1:0] top_cnt_o,
  output logic [DW-1:0] depth_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          ovf_o
);
  localparam int IW = idx_w(DEPTH);

  logic [DEPTH-1:0][AW-1:0] start_q;
  logic [DEPTH-1:0][AW-1:0] end_q;
  logic [DEPTH-1:0][CW-1:0] cnt_q;
  logic [DW-1:0]            depth_q;
  logic                     ovf_q;
  logic [IW-1:0]            top_idx;
  logic [IW-1:0]            push_idx;

  assign top_idx  = IW'(depth_q - DW'(1));
  assign push_idx = IW'(depth_q);
  assign empty_o  = (depth_q == '0);
  assign full_o   = (depth_q == DW'(DEPTH));

  assign top_start_o = start_q[top_idx];
  assign top_end_o   = end_q[top_idx];
  assign top_cnt_o   = cnt_q[top_idx];
  assign depth_o     = depth_q;
  assign ovf_o       = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= '0;
      end_q   <= '0;
      cnt_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (upd_i && !empty_o) cnt_q[top_idx] <= upd_cnt_i;
      unique case (op_i)
        OP_PUSH: begin
          if (full_o) begin
            ovf_q <= 1'b1;
          end else begin
            start_q[push_idx] <= push_start_i;
            end_q[push_idx]   <= push_end_i;
            cnt_q[push_idx]   <= push_cnt_i;
            depth_q           <= depth_q + DW'(1);
          end
        end
        OP_POP: begin
          if (!empty_o) begin
            start_q[top_idx] <= '0;
            end_q[top_idx]   <= '0;
            cnt_q[top_idx]   <= '0;
            depth_q          <= depth_q - DW'(1);
          end
        end
        // Pop followed by push lands in the same slot: occupancy unchanged.
        OP_REPL: begin
          if (!empty_o) begin
            start_q[top_idx] <= push_start_i;
            end_q[top_idx]   <= push_end_i;
            cnt_q[top_idx]   <= push_cnt_i;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/dsp_loop_ctrl.sv
// Zero-overhead hardware loop controller: end-address match, jump priority mux and count decrement.
module dsp_loop_ctrl
  import dsp_loop_ctrl_pkg::*;
#(
  parameter int MEM_ADDR_LEN = MEM_ADDR_LEN_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEPTH        = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [MEM_ADDR_LEN-1:0]      pc,
  input  logic                         loop_start,
  input  logic [CNT_W-1:0]             loop_count,
  input  logic [MEM_ADDR_LEN-1:0]      loop_end,
  input  logic                         br_flag,
  input  logic [MEM_ADDR_LEN-1:0]      br_addr,
  input  logic                         loop_abort,
  output logic                         jump_flag,
  output logic [MEM_ADDR_LEN-1:0]      jump_addr,
  output logic                         loop_active,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         ovf_err
);
  localparam int DW = $clog2(DEPTH + 1);

  logic [MEM_ADDR_LEN-1:0] top_start, top_end;
  logic [CNT_W-1:0]        top_cnt;
  logic                    empty, full;
  logic                    skip, push_req, match, match_eff, more, abort, pop, dec;
  stk_op_e                 op;

  assign skip      = loop_start && (loop_count == '0);
  assign push_req  = loop_start && (loop_count != '0);
  assign match     = !empty && (pc == top_end);
  // A higher-priority jump this cycle means the loop end was not really retired.
  assign match_eff = match && !br_flag && !skip;
  assign more      = (top_cnt > CNT_W'(1));
  assign abort     = loop_abort && !empty;
  assign pop       = abort || (match_eff && !more);
  assign dec       = match_eff && more && !abort;

  always_comb begin
    op = OP_NONE;
    if (push_req && pop) op = OP_REPL;
    else if (push_req)   op = OP_PUSH;
    else if (pop)        op = OP_POP;
  end

  always_comb begin
    jump_flag = 1'b0;
    jump_addr = '0;
    if (br_flag) begin
      jump_flag = 1'b1;
      jump_addr = br_addr;
    end else if (skip) begin
      jump_flag = 1'b1;
      jump_addr = loop_end + MEM_ADDR_LEN'(1);
    end else if (match && more) begin
      jump_flag = 1'b1;
      jump_addr = top_start;
    end
  end

  dsp_loop_stack #(
    .AW    (MEM_ADDR_LEN),
    .CW    (CNT_W),
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_stack (
    .clk          (clk),
    .rst          (rst),
    .op_i         (op),
    .push_start_i (pc + MEM_ADDR_LEN'(1)),
    .push_end_i   (loop_end),
    .push_cnt_i   (loop_count),
    .upd_i        (dec),
    .upd_cnt_i    (top_cnt - CNT_W'(1)),
    .top_start_o  (top_start),
    .top_end_o    (top_end),
    .top_cnt_o    (top_cnt),
    .depth_o      (depth),
    .empty_o      (empty),
    .full_o       (full),
    .ovf_o        (ovf_err)
  );

  assign loop_active = !empty;
endmodule

// File: tb/tb_dsp_loop_ctrl.sv
// Directed bench for dsp_loop_ctrl: one task per scenario, hand-computed expectations.
module tb_dsp_loop_ctrl;
  localparam int AW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc;
  logic          loop_start;
  logic [CW-1:0] loop_count;
  logic [AW-1:0] loop_end;
  logic          br_flag;
  logic [AW-1:0] br_addr;
  logic          loop_abort;
  logic          jump_flag;
  logic [AW-1:0] jump_addr;
  logic          loop_active;
  logic [2:0]    depth;
  logic          ovf_err;

  int errs   = 0;
  int checks = 0;

  dsp_loop_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .loop_start  (loop_start),
    .loop_count  (loop_count),
    .loop_end    (loop_end),
    .br_flag     (br_flag),
    .br_addr     (br_addr),
    .loop_abort  (loop_abort),
    .jump_flag   (jump_flag),
    .jump_addr   (jump_addr),
    .loop_active (loop_active),
    .depth       (depth),
    .ovf_err     (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    loop_start = 1'b0;
    loop_count = '0;
    loop_end   = '0;
    br_flag    = 1'b0;
    br_addr    = '0;
    loop_abort = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] p, input logic [CW-1:0] c, input logic [AW-1:0] e);
    pc = p; loop_start = 1'b1; loop_count = c; loop_end = e;
    cyc();
    loop_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle(); pc = '0;
    rst = 1'b1; br_flag = 1'b1; br_addr = 16'h0033;
    cyc();
    checks++; if (jump_flag !== 1'b1 || jump_addr !== 16'h0033) begin
      errs++; $display("FAIL rst_br: jf=%0b ja=%0d want 1/51", jump_flag, jump_addr); end
    rst = 1'b0; br_flag = 1'b0; #1;
    checks++; if (depth !== 3'd0 || loop_active !== 1'b0 || ovf_err !== 1'b0) begin
      errs++; $display("FAIL rst_state: depth=%0d act=%0b ovf=%0b want 0/0/0", depth, loop_active, ovf_err); end
    checks++; if (jump_flag !== 1'b0 || jump_addr !== '0) begin
      errs++; $display("FAIL rst_jump: jf=%0b ja=%0d want 0/0", jump_flag, jump_addr); end
  endtask

  task automatic test_basic_loop();
    idle();
    pc = 16'd10; loop_start = 1'b1; loop_count = 16'd3; loop_end = 16'd12; #1;
    checks++; if (jump_flag !== 1'b0) begin
      errs++; $display("FAIL basic_push_nojump: jf=%0b want 0", jump_flag); end
    cyc(); loop_start = 1'b0;
    checks++; if (depth !== 3'd1 || loop_active !== 1'b1) begin
      errs++; $display("FAIL basic_depth1: depth=%0d act=%0b want 1/1", depth, loop_active); end
    for (int p = 0; p < 3; p++) begin
      pc = 16'd11; #1;
      checks++; if (jump_flag !== 1'b0) begin
        errs++; $display("FAIL basic_pc11_pass%0d: jf=%0b want 0", p, jump_flag); end
      cyc();
      pc = 16'd12; #1;
      checks++; if (jump_flag !== (p < 2) || jump_addr !== ((p < 2) ? 16'd11 : 16'd0)) begin
        errs++; $display("FAIL basic_end_pass%0d: jf=%0b ja=%0d want %0b/%0d",
                         p, jump_flag, jump_addr, (p < 2), (p < 2) ? 11 : 0); end
      cyc();
      checks++; if (depth !== ((p < 2) ? 3'd1 : 3'd0)) begin
        errs++; $display("FAIL basic_depth_pass%0d: depth=%0d want %0d", p, depth, (p < 2) ? 1 : 0); end
    end
  endtask

  task automatic test_skip();
    idle();
    pc = 16'd20; loop_start = 1'b1; loop_count = 16'd0; loop_end = 16'd25; #1;
    checks++; if (jump_flag !== 1'b1 || jump_addr !== 16'd26) begin
      errs++; $display("FAIL skip_jump: jf=%0b ja=%0d want 1/26", jump_flag, jump_addr); end
    br_flag = 1'b1; br_addr = 16'd7; #1;
    checks++; if (jump_flag !== 1'b1 || jump_addr !== 16'd7) begin
      errs++; $display("FAIL skip_br_prio: jf=%0b ja=%0d want 1/7", jump_flag, jump_addr); end
    br_flag = 1'b0;
    loop_end = 16'hFFFF; #1;
    checks++; if (jump_flag !== 1'b1 || jump_addr !== 16'h0000) begin
      errs++; $display("FAIL skip_wrap: jf=%0b ja=%0h want 1/0", jump_flag, jump_addr); end
    cyc(); loop_start = 1'b0;
    checks++; if (depth !== 3'd0) begin
      errs++; $display("FAIL skip_depth: depth=%0d want 0", depth); end
  endtask

  task automatic test_nested();
    int body = 0;
    int oj = 0;
    int ij = 0;
    bit done = 1'b0;
    logic [AW-1:0] nxt;
    idle(); do_reset();
    pc = 16'd0;
    for (int c = 0; c < 200 && !done; c++) begin
      loop_start = (pc == 16'd0) || (pc == 16'd2);
      loop_count = 16'd2;
      loop_end   = (pc == 16'd0) ? 16'd9 : 16'd5;
      #1;
      if (pc == 16'd4) body++;
      if (jump_flag && jump_addr == 16'd1) oj++;
      if (jump_flag && jump_addr == 16'd3) ij++;
      nxt = jump_flag ? jump_addr : pc + 16'd1;
      @(posedge clk); #1;
      pc = nxt;
      if (pc == 16'd10) done = 1'b1;
    end
    loop_start = 1'b0;
    checks++; if (!done) begin
      errs++; $display("FAIL nest_timeout: pc=%0d never reached 10", pc); end
    checks++; if (body !== 4) begin
      errs++; $display("FAIL nest_body: count=%0d want 4", body); end
    checks++; if (oj !== 1 || ij !== 2) begin
      errs++; $display("FAIL nest_jumps: outer=%0d inner=%0d want 1/2", oj, ij); end
    checks++; if (depth !== 3'd0) begin
      errs++; $display("FAIL nest_depth: depth=%0d want 0", depth); end
  endtask

  task automatic test_overflow_replace();
    idle(); do_reset();
    for (int i = 0; i < 4; i++) push(16'(100 + i), 16'd5, 16'd200);
    checks++; if (depth !== 3'd4 || ovf_err !== 1'b0) begin
      errs++; $display("FAIL ovf_fill: depth=%0d ovf=%0b want 4/0", depth, ovf_err); end
    // Full stack: abort + start replaces the top without overflow.
    pc = 16'd50; loop_start = 1'b1; loop_count = 16'd2; loop_end = 16'd60; loop_abort = 1'b1;
    cyc(); loop_start = 1'b0; loop_abort = 1'b0;
    checks++; if (depth !== 3'd4 || ovf_err !== 1'b0) begin
      errs++; $display("FAIL repl_depth: depth=%0d ovf=%0b want 4/0", depth, ovf_err); end
    pc = 16'd60; #1;
    checks++; if (jump_flag !== 1'b1 || jump_addr !== 16'd51) begin
      errs++; $display("FAIL repl_top: jf=%0b ja=%0d want 1/51", jump_flag, jump_addr); end
    push(16'd104, 16'd5, 16'd200);
    checks++; if (depth !== 3'd4 || ovf_err !== 1'b1) begin
      errs++; $display("FAIL ovf_set: depth=%0d ovf=%0b want 4/1", depth, ovf_err); end
    pc = 16'd300; cyc(); cyc(); cyc();
    checks++; if (ovf_err !== 1'b1) begin
      errs++; $display("FAIL ovf_sticky: ovf=%0b want 1", ovf_err); end
    do_reset();
    checks++; if (ovf_err !== 1'b0 || depth !== 3'd0) begin
      errs++; $display("FAIL ovf_clear: ovf=%0b depth=%0d want 0/0", ovf_err, depth); end
  endtask

  task automatic test_branch_abort();
    idle(); do_reset();
    push(16'd10, 16'd2, 16'd12);
    pc = 16'd12; br_flag = 1'b1; br_addr = 16'd40; #1;
    checks++; if (jump_flag !== 1'b1 || jump_addr !== 16'd40) begin
      errs++; $display("FAIL br_wins: jf=%0b ja=%0d want 1/40", jump_flag, jump_addr); end
    cyc(); br_flag = 1'b0; #1;
    // Count still 2, so the end match must still loop back.
    checks++; if (depth !== 3'd1 || jump_flag !== 1'b1 || jump_addr !== 16'd11) begin
      errs++; $display("FAIL br_no_dec: depth=%0d jf=%0b ja=%0d want 1/1/11", depth, jump_flag, jump_addr); end
    pc = 16'd40; loop_abort = 1'b1; #1;
    checks++; if (jump_flag !== 1'b0) begin
      errs++; $display("FAIL abort_nojump: jf=%0b want 0", jump_flag); end
    cyc();
    checks++; if (depth !== 3'd0) begin
      errs++; $display("FAIL abort_pop: depth=%0d want 0", depth); end
    cyc(); loop_abort = 1'b0;
    checks++; if (depth !== 3'd0 || loop_active !== 1'b0) begin
      errs++; $display("FAIL abort_empty: depth=%0d act=%0b want 0/0", depth, loop_active); end
  endtask

  task automatic test_abort_match();
    idle(); do_reset();
    push(16'd30, 16'd3, 16'd50);
    push(16'd35, 16'd1, 16'd40);
    pc = 16'd40; loop_abort = 1'b1; #1;
    checks++; if (jump_flag !== 1'b0) begin
      errs++; $display("FAIL abmatch_jump: jf=%0b want 0", jump_flag); end
    cyc(); loop_abort = 1'b0;
    checks++; if (depth !== 3'd1) begin
      errs++; $display("FAIL abmatch_single_pop: depth=%0d want 1", depth); end
    pc = 16'd50; #1;
    checks++; if (jump_flag !== 1'b1 || jump_addr !== 16'd31) begin
      errs++; $display("FAIL abmatch_outer: jf=%0b ja=%0d want 1/31", jump_flag, jump_addr); end
  endtask

  task automatic test_rst_mid();
    idle(); do_reset();
    push(16'd5, 16'd3, 16'd15);
    push(16'd6, 16'd3, 16'd8);
    pc = 16'd7;
    checks++; if (depth !== 3'd2) begin
      errs++; $display("FAIL rstmid_pre: depth=%0d want 2", depth); end
    do_reset();
    checks++; if (depth !== 3'd0 || ovf_err !== 1'b0 || loop_active !== 1'b0) begin
      errs++; $display("FAIL rstmid_state: depth=%0d ovf=%0b act=%0b want 0/0/0", depth, ovf_err, loop_active); end
    pc = 16'd8; #1;
    checks++; if (jump_flag !== 1'b0) begin
      errs++; $display("FAIL rstmid_inner_end: jf=%0b want 0", jump_flag); end
    pc = 16'd15; #1;
    checks++; if (jump_flag !== 1'b0) begin
      errs++; $display("FAIL rstmid_outer_end: jf=%0b want 0", jump_flag); end
  endtask

  initial begin
    idle(); rst = 1'b1; pc = '0;
    test_reset();
    test_basic_loop();
    test_skip();
    test_nested();
    test_overflow_replace();
    test_branch_abort();
    test_abort_match();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
